// File: rtl/serial_sub_unit.sv
// -----------------------------------------------------------------------------
// serial_sub_unit
//
// Bit-serial unsigned subtractor: computes minuend - subtrahend one bit per
// clock, LSB first, with valid/ready handshakes on input and output. A
// transaction takes exactly WIDTH RUN cycles between the input and output
// handshakes. No two operations overlap.
//
// Optional feature (compile-time macro SERIAL_SUB_SAT_EN):
//   defined   - a result that borrows is clamped to 0 (out_zero=1 and
//               out_borrow=1 are both reported).
//   undefined - plain modular (wrap-around) difference.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-high
//   in_valid       operands presented
//   in_ready       unit can accept operands (high only while idle)
//   in_minuend     operand A
//   in_subtrahend  operand B
//   out_valid      result available (high only while holding a result)
//   out_ready      consumer accepts result
//   out_diff       (A - B) mod 2^WIDTH (or 0 on borrow when saturating)
//   out_borrow     1 when A < B (unsigned)
//   out_zero       1 when out_diff == 0
// -----------------------------------------------------------------------------
module serial_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_minuend,
    input  logic [WIDTH-1:0] in_subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sh_reg;      // partial result, filled from the MSB end
    logic             bc_reg;      // running borrow between bit positions
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] diff_reg;    // published result, only updated on completion
    logic             borrow_reg;
    logic             zero_reg;

    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             bc_next;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] res_diff;
    logic             res_zero;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs.
    assign a0      = a_reg[0];
    assign b0      = b_reg[0];
    assign d_bit   = a0 ^ b0 ^ bc_reg;
    assign bc_next = (~a0 & b0) | (~(a0 ^ b0) & bc_reg);

    // New difference bit enters at the top; after WIDTH shifts the first
    // (LSB) bit has reached position 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sh_next[gi] = sh_reg[gi+1];
        end
    endgenerate
    assign sh_next[WIDTH-1] = d_bit;

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_SAT_EN
    assign res_diff = bc_next ? '0 : sh_next;
`else
    assign res_diff = sh_next;
`endif
    assign res_zero = (res_diff == '0);

    // Handshake outputs are pure state decodes: no input-to-output paths.
    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_diff   = diff_reg;
    assign out_borrow = borrow_reg;
    assign out_zero   = zero_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sh_reg     <= '0;
            bc_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_minuend;
                        b_reg     <= in_subtrahend;
                        bc_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    sh_reg <= sh_next;
                    bc_reg <= bc_next;
                    if (last_bit) begin
                        // Counter is left at WIDTH-1 so it never wraps.
                        diff_reg   <= res_diff;
                        borrow_reg <= bc_next;
                        zero_reg   <= res_zero;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_unit
//
// Self-checking bench for serial_sub_unit (WIDTH=8). A transaction-level model
// (accept -> WIDTH cycles -> result held until consumed) predicts every output
// on every cycle; directed cases additionally pin literal results.
// Honours SERIAL_SUB_SAT_EN for the expected underflow results.
// -----------------------------------------------------------------------------
module tb_serial_sub_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_minuend;
    logic [W-1:0] in_subtrahend;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_diff;
    logic         out_borrow;
    logic         out_zero;

    int tests;
    int fails;
    bit check_en;

    serial_sub_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_minuend   (in_minuend),
        .in_subtrahend(in_subtrahend),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_diff     (out_diff),
        .out_borrow   (out_borrow),
        .out_zero     (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit           m_ready;
    bit           m_valid;
    int           m_left;      // cycles until the pending result appears
    logic [W-1:0] m_diff;
    bit           m_borrow;
    bit           m_zero;
    logic [W-1:0] p_diff;
    bit           p_borrow;

    initial begin
        m_ready = 1'b1; m_valid = 1'b0; m_left = 0;
        m_diff = '0; m_borrow = 1'b0; m_zero = 1'b0;
        p_diff = '0; p_borrow = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1; m_valid = 1'b0; m_left = 0;
            m_diff = '0; m_borrow = 1'b0; m_zero = 1'b0;
        end else if (m_ready && in_valid) begin
            m_ready  = 1'b0;
            m_left   = W;
            p_diff   = in_minuend - in_subtrahend;
            p_borrow = (in_minuend < in_subtrahend);
`ifdef SERIAL_SUB_SAT_EN
            if (p_borrow) p_diff = '0;
`endif
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid  = 1'b1;
                m_diff   = p_diff;
                m_borrow = p_borrow;
                m_zero   = (p_diff == '0);
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    // Every-cycle comparison, sampled away from the active edge.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            check("cyc_in_ready", 32'(in_ready), 32'(m_ready));
            check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            check("cyc_out_diff", 32'(out_diff), 32'(m_diff));
            check("cyc_out_borrow", 32'(out_borrow), 32'(m_borrow));
            check("cyc_out_zero", 32'(out_zero), 32'(m_zero));
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and finish 1 time unit after a rising edge.
    task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bit rdy;
        bit done;
        done = 1'b0;
        in_minuend    = a;
        in_subtrahend = b;
        in_valid      = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input bit noise, output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (noise) begin
                // Unit is busy: these operands must be ignored.
                in_valid      = 1'($urandom);
                in_minuend    = W'($urandom);
                in_subtrahend = W'($urandom);
            end
        end
        in_valid = 1'b0;
        if (lat == 0) lat = 100;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ed, input bit eb, input bit ez);
        int lat;
        do_accept(a, b);
        wait_valid(1'b0, lat);
        $display("[TB] %s A=0x%02h B=0x%02h -> diff=0x%02h borrow=%0b zero=%0b lat=%0d",
                 name, a, b, out_diff, out_borrow, out_zero, lat);
        check({name, "_lat"}, 32'(lat), 32'(W));
        check({name, "_diff"}, 32'(out_diff), 32'(ed));
        check({name, "_borrow"}, 32'(out_borrow), 32'(eb));
        check({name, "_zero"}, 32'(out_zero), 32'(ez));
        drain();
    endtask

    initial begin
        int lat;
        logic [W-1:0] a;
        logic [W-1:0] b;
        tests = 0; fails = 0; check_en = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_minuend = '0; in_subtrahend = '0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_diff", 32'(out_diff), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Basic subtract with out_ready held high.
        out_ready = 1'b1;
        do_accept(8'h5A, 8'h23);
        wait_valid(1'b0, lat);
        $display("[TB] basic A=0x5a B=0x23 -> diff=0x%02h borrow=%0b zero=%0b lat=%0d",
                 out_diff, out_borrow, out_zero, lat);
        check("basic_lat", 32'(lat), 32'd8);
        check("basic_diff", 32'(out_diff), 32'h37);
        check("basic_borrow", 32'(out_borrow), 32'd0);
        check("basic_zero", 32'(out_zero), 32'd0);
        @(posedge clk); #1;
        check("basic_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Underflow.
`ifdef SERIAL_SUB_SAT_EN
        run_lit("underflow", 8'h10, 8'h20, 8'h00, 1'b1, 1'b1);
`else
        run_lit("underflow", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
`endif

        // Equal / extremes back-to-back.
        run_lit("equal", 8'h80, 8'h80, 8'h00, 1'b0, 1'b1);
`ifdef SERIAL_SUB_SAT_EN
        run_lit("zero_minus_max", 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
`else
        run_lit("zero_minus_max", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
`endif
        run_lit("max_minus_zero", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Backpressure: result held 15 cycles while new operands wait.
        do_accept(8'h9C, 8'h41);
        wait_valid(1'b0, lat);
        check("bp_lat", 32'(lat), 32'd8);
        in_minuend = 8'h11; in_subtrahend = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("bp_hold_diff", 32'(out_diff), 32'h5B);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        $display("[TB] backpressure A=0x9c B=0x41 -> diff=0x%02h held 15 cycles", out_diff);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;          // pending operands accepted here
        in_valid = 1'b0;
        check("bp_accept_in_ready", 32'(in_ready), 32'd0);
        wait_valid(1'b0, lat);
        $display("[TB] queued A=0x11 B=0x01 -> diff=0x%02h lat=%0d", out_diff, lat);
        check("bp_next_lat", 32'(lat), 32'd8);
        check("bp_next_diff", 32'(out_diff), 32'h10);
        drain();

        // Reset during RUN: partial result discarded.
        do_accept(8'hC3, 8'h3C);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_diff", 32'(out_diff), 32'd0);
        $display("[TB] reset mid-RUN A=0xc3 B=0x3c -> aborted");
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_lit("after_reset", 8'h07, 8'h02, 8'h05, 1'b0, 1'b0);

        // Randomised traffic with busy-time noise and output stalls.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: begin a = W'($urandom); b = a; end
                1: begin a = '0; b = W'($urandom); end
                2: begin a = W'($urandom); b = '0; end
                3: begin a = W'($urandom); b = '1; end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            do_accept(a, b);
            wait_valid(1'b1, lat);
            $display("[TB] rand%0d A=0x%02h B=0x%02h -> diff=0x%02h borrow=%0b zero=%0b lat=%0d",
                     n, a, b, out_diff, out_borrow, out_zero, lat);
            check("rand_lat", 32'(lat), 32'(W));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            drain();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
